// File: rtl/prog_loader.sv
// Byte-stream program loader: sync, length, payload written to RAM one cycle after acceptance, then checksum.
// rx_ready is a pure function of state; idle gaps inside a session are bounded by TIMEOUT.
module prog_loader #(
   parameter logic [7:0]  SYNC    = 8'hA5,
   parameter logic [15:0] TIMEOUT = 16'd50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_data,
   output logic       mem_we,
   output logic       cpu_hold,
   output logic       busy,
   output logic       done,
   output logic       error
);

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_LEN, S_LOAD, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t      state, state_nxt;
   logic [8:0]  len;
   logic [8:0]  cnt;
   logic [7:0]  csum;
   logic [15:0] tmo;
   logic        accept;
   logic        open_sess;
   logic        tmo_hit;

   assign rx_ready = (state == S_SYNC) || (state == S_LEN) ||
                     (state == S_LOAD) || (state == S_CSUM);
   assign busy     = rx_ready;
   assign cpu_hold = (state != S_DONE);
   assign done     = (state == S_DONE);
   assign error    = (state == S_ERR);
   assign accept   = rx_valid && rx_ready;
   // tmo counts idle cycles already elapsed; this cycle would be the TIMEOUT-th one
   assign tmo_hit  = ((tmo + 16'd1) == TIMEOUT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      open_sess = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_nxt = S_SYNC;
               open_sess = 1'b1;
            end
         end
         S_SYNC: begin
            if (accept && (rx_data == SYNC)) state_nxt = S_LEN;
         end
         S_LEN: begin
            if (accept)       state_nxt = S_LOAD;
            else if (tmo_hit) state_nxt = S_ERR;
         end
         S_LOAD: begin
            if (accept) begin
               if ((cnt + 9'd1) == len) state_nxt = S_CSUM;
            end else if (tmo_hit) begin
               state_nxt = S_ERR;
            end
         end
         S_CSUM: begin
            if (accept)       state_nxt = (rx_data == csum) ? S_DONE : S_ERR;
            else if (tmo_hit) state_nxt = S_ERR;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len      <= 9'd0;
         cnt      <= 9'd0;
         csum     <= 8'd0;
         tmo      <= 16'd0;
         mem_we   <= 1'b0;
         mem_addr <= 8'd0;
         mem_data <= 8'd0;
      end else begin
         mem_we <= 1'b0;
         if (open_sess) begin
            cnt  <= 9'd0;
            csum <= 8'd0;
            tmo  <= 16'd0;
         end else if ((state == S_LEN) || (state == S_LOAD) || (state == S_CSUM)) begin
            tmo <= accept ? 16'd0 : tmo + 16'd1;
         end
         if (accept && (state == S_LEN))
            len <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
         if (accept && (state == S_LOAD)) begin
            mem_we   <= 1'b1;
            mem_addr <= cnt[7:0];
            mem_data <= rx_data;
            cnt      <= cnt + 9'd1;
            csum     <= csum + rx_data;
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed sessions plus randomized sessions against a stream-level model.
module tb_prog_loader;

   localparam logic [7:0]  SYNC_B = 8'hA5;
   localparam logic [15:0] TMO    = 16'd40;

   typedef logic [7:0] bq_t[$];

   logic       clk, reset, start, rx_valid, rx_ready;
   logic [7:0] rx_data, mem_addr, mem_data;
   logic       mem_we, cpu_hold, busy, done, error;

   logic [15:0] got_wr[$];
   logic [15:0] exp_wr[$];
   int checks, errors, we_in_reset, gap_max;

   prog_loader #(.SYNC(SYNC_B), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we) got_wr.push_back({mem_addr, mem_data});
      if (mem_we && reset) we_in_reset++;
   end

   // Stream-level reference: outcome 0 = still in session, 1 = done, 2 = error
   task automatic model(input bq_t s, output int oc);
      int i, n;
      logic [7:0] sum;
      exp_wr.delete();
      oc = 0;
      i = 0;
      while (i < s.size() && s[i] != SYNC_B) i++;
      if (i >= s.size()) return;
      i++;
      if (i >= s.size()) return;
      n = (s[i] == 8'h00) ? 256 : int'(s[i]);
      i++;
      sum = 8'h00;
      for (int k = 0; k < n; k++) begin
         if (i >= s.size()) return;
         exp_wr.push_back({8'(k), s[i]});
         sum = sum + s[i];
         i++;
      end
      if (i >= s.size()) return;
      oc = (s[i] == sum) ? 1 : 2;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      repeat ($urandom_range(0, gap_max)) begin
         rx_data = 8'($urandom);
         @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++; errors++;
         $display("FAIL send_byte_timeout byte=%02h rx_ready never rose", b);
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic do_session(input string name, input bq_t s);
      int oc;
      logic [3:0] exp_flags;
      model(s, oc);
      got_wr.delete();
      pulse_start();
      foreach (s[i]) send_byte(s[i]);
      repeat (2) @(negedge clk);
      checks++;
      if (got_wr.size() !== exp_wr.size()) begin
         errors++;
         $display("FAIL %s write_count got=%0d exp=%0d", name, got_wr.size(), exp_wr.size());
      end
      for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
         checks++;
         if (got_wr[i] !== exp_wr[i]) begin
            errors++;
            $display("FAIL %s write[%0d] got=%04h exp=%04h", name, i, got_wr[i], exp_wr[i]);
         end
      end
      exp_flags = (oc == 1) ? 4'b1000 : (oc == 2) ? 4'b0110 : 4'b0011;
      checks++;
      if ({done, error, cpu_hold, busy} !== exp_flags) begin
         errors++;
         $display("FAIL %s flags{done,error,hold,busy} got=%b exp=%b", name, {done, error, cpu_hold, busy}, exp_flags);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (2) @(negedge clk);
      checks++;
      if ({rx_ready, mem_we, mem_addr, mem_data, cpu_hold, busy, done, error} !== 22'b0_0_00000000_00000000_1_0_0_0) begin
         errors++;
         $display("FAIL reset_outputs got=%b", {rx_ready, mem_we, mem_addr, mem_data, cpu_hold, busy, done, error});
      end
      reset = 1'b0;
      rx_valid = 1'b1; rx_data = SYNC_B;
      repeat (4) @(negedge clk);
      checks++;
      if ({rx_ready, busy, got_wr.size() == 0} !== 3'b001) begin
         errors++;
         $display("FAIL idle_ignores_bytes rx_ready=%b busy=%b writes=%0d exp 0/0/0", rx_ready, busy, got_wr.size());
      end
      rx_valid = 1'b0;
   endtask

   task automatic test_directed();
      bq_t s;
      s = '{8'h00, 8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h60};
      do_session("good_csum", s);
      s[6] = 8'h61;
      do_session("bad_csum", s);
   endtask

   task automatic test_len256();
      bq_t s;
      s = '{8'hA5, 8'h00};
      for (int i = 0; i < 256; i++) s.push_back(8'(i));
      s.push_back(8'h80);
      gap_max = 0;
      do_session("len256", s);
      gap_max = 2;
   endtask

   task automatic test_timeout();
      int n;
      got_wr.delete();
      pulse_start();
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h5C);
      repeat (int'(TMO) - 3) @(negedge clk);
      checks++;
      if ({busy, error} !== 2'b10) begin
         errors++;
         $display("FAIL timeout_early busy=%b error=%b exp busy=1 error=0", busy, error);
      end
      n = 0;
      while (!error && n < 6) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if ({done, error, cpu_hold, rx_ready} !== 4'b0110) begin
         errors++;
         $display("FAIL timeout_err flags{done,error,hold,rdy} got=%b exp=0110", {done, error, cpu_hold, rx_ready});
      end
      checks++;
      if (got_wr.size() !== 1) begin
         errors++;
         $display("FAIL timeout_writes got=%0d exp=1", got_wr.size());
      end
   endtask

   task automatic test_sync_no_timeout();
      pulse_start();
      send_byte(8'h3C); send_byte(8'hA4);
      repeat (int'(TMO) + 10) @(negedge clk);
      checks++;
      if ({busy, error, rx_ready} !== 3'b101) begin
         errors++;
         $display("FAIL sync_no_timeout busy/error/rdy got=%b exp=101", {busy, error, rx_ready});
      end
      got_wr.delete();
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h77); send_byte(8'h77);
      @(negedge clk);
      checks++;
      if ({done, error, got_wr.size() == 1} !== 3'b101) begin
         errors++;
         $display("FAIL sync_then_load done/error/onewrite got=%b exp=101", {done, error, got_wr.size() == 1});
      end
   endtask

   task automatic test_reset_mid_load();
      got_wr.delete();
      we_in_reset = 0;
      pulse_start();
      send_byte(8'hA5); send_byte(8'h05); send_byte(8'h11);
      rx_valid = 1'b1; rx_data = 8'h22;
      @(posedge clk);
      #1 reset = 1'b1;
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({rx_ready, mem_we, mem_addr, mem_data, cpu_hold, busy, done, error} !== 22'b0_0_00000000_00000000_1_0_0_0) begin
         errors++;
         $display("FAIL midload_reset_outputs got=%b", {rx_ready, mem_we, mem_addr, mem_data, cpu_hold, busy, done, error});
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ((got_wr.size() !== 1) || (got_wr[0] !== 16'h0011) || (we_in_reset !== 0)) begin
         errors++;
         $display("FAIL midload_cancel writes=%0d first=%04h we_in_reset=%0d exp 1/0011/0", got_wr.size(), got_wr.size() > 0 ? got_wr[0] : 16'hxxxx, we_in_reset);
      end
      do_session("after_reset", '{8'hA5, 8'h02, 8'h40, 8'h41, 8'h81});
   endtask

   task automatic test_start_in_load();
      bq_t s;
      int oc;
      s = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'hF0, 8'h0F, 8'h02};
      model(s, oc);
      got_wr.delete();
      pulse_start();
      for (int i = 0; i < 4; i++) send_byte(s[i]);
      pulse_start();
      checks++;
      if ({busy, rx_ready} !== 2'b11) begin
         errors++;
         $display("FAIL start_in_load busy/rdy got=%b exp=11", {busy, rx_ready});
      end
      for (int i = 4; i < s.size(); i++) send_byte(s[i]);
      repeat (2) @(negedge clk);
      checks++;
      if ((got_wr.size() !== exp_wr.size()) || (oc != 1) || (done !== 1'b1)) begin
         errors++;
         $display("FAIL start_in_load_result writes=%0d exp=%0d done=%b", got_wr.size(), exp_wr.size(), done);
      end
      for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
         checks++;
         if (got_wr[i] !== exp_wr[i]) begin
            errors++;
            $display("FAIL start_in_load write[%0d] got=%04h exp=%04h", i, got_wr[i], exp_wr[i]);
         end
      end
   endtask

   task automatic test_random();
      bq_t s;
      logic [7:0] sum, b;
      int n;
      for (int r = 0; r < 10; r++) begin
         s.delete();
         repeat ($urandom_range(0, 3)) begin
            b = 8'($urandom);
            if (b == SYNC_B) b = 8'h00;
            s.push_back(b);
         end
         n = (r == 9) ? 256 : int'($urandom_range(1, 24));
         s.push_back(SYNC_B);
         s.push_back(8'(n));
         sum = 8'h00;
         for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            s.push_back(b);
            sum = sum + b;
         end
         s.push_back(($urandom_range(0, 2) == 0) ? sum ^ 8'(1 << $urandom_range(0, 7)) : sum);
         do_session($sformatf("random%0d", r), s);
      end
   endtask

   initial begin
      checks = 0; errors = 0; we_in_reset = 0; gap_max = 2;
      test_reset();
      test_directed();
      test_len256();
      test_timeout();
      test_sync_no_timeout();
      test_reset_mid_load();
      test_start_in_load();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter SYNC, default 8'hA5: session sync byte; non-matching bytes before it are discarded.
REQ-002 Parameter TIMEOUT, default 16'd50000: maximum idle cycles between accepted bytes inside a session.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  single-cycle request to open a load session.
REQ-006 rx_data  in  8  incoming byte stream.
REQ-007 rx_valid  in  1  rx_data valid this cycle.
REQ-008 rx_ready  out  1  loader accepts rx_data this cycle.
REQ-009 mem_addr  out  8  RAM write address.
REQ-010 mem_data  out  8  RAM write data.
REQ-011 mem_we  out  1  RAM write strobe, one cycle per byte.
REQ-012 cpu_hold  out  1  holds the CPU clocks/FSM halted while high.
REQ-013 busy  out  1  session in progress.
REQ-014 done  out  1  last session completed with a valid checksum.
REQ-015 error  out  1  last session failed (bad checksum or timeout).

Function
REQ-016 The block SHALL implement states IDLE, SYNC, LEN, LOAD, CSUM, DONE, ERR.
REQ-017 A byte SHALL be accepted only in a cycle where rx_valid and rx_ready are both 1.
REQ-018 rx_ready SHALL be 1 exactly in SYNC, LEN, LOAD and CSUM, and 0 in IDLE, DONE and ERR.
REQ-019 start in IDLE, DONE or ERR SHALL move to SYNC next cycle, clearing done, error, checksum, byte count and timeout counter; start in any other state SHALL be ignored.
REQ-020 SYNC: an accepted byte equal to SYNC SHALL move to LEN; any other accepted byte SHALL be discarded without leaving SYNC.
REQ-021 LEN: the accepted byte SHALL be latched as payload length N, with 8'h00 meaning 256; then move to LOAD.
REQ-022 LOAD: the k-th accepted byte (k = 0..N-1) SHALL produce, in the following cycle, mem_we=1, mem_addr=k, mem_data=byte.
REQ-023 mem_we SHALL be high for exactly one cycle per payload byte and 0 in all other cycles.
REQ-024 The running checksum SHALL be the 8-bit sum of payload bytes, wrapping modulo 256.
REQ-025 After the N-th payload byte is accepted the block SHALL move to CSUM; with N=256 the address SHALL reach 8'hFF without wrapping to further writes.
REQ-026 CSUM: an accepted byte equal to the checksum SHALL move to DONE with done=1; otherwise move to ERR with error=1.
REQ-027 The timeout counter SHALL reset on every accepted byte and on entering SYNC; reaching TIMEOUT in LEN, LOAD or CSUM SHALL move to ERR with error=1; SYNC SHALL never time out.
REQ-028 cpu_hold SHALL be 0 only in DONE and 1 in every other state.
REQ-029 busy SHALL be 1 in SYNC, LEN, LOAD, CSUM and 0 otherwise.
REQ-030 done and error SHALL never both be 1 and SHALL hold their value until the next start or reset.
REQ-031 DONE and ERR SHALL be left only by start or reset.

Reset
REQ-032 Asserting reset at any time, including mid-LOAD, SHALL force IDLE immediately: rx_ready=0, mem_we=0, mem_addr=0, mem_data=0, cpu_hold=1, busy=0, done=0, error=0, checksum and counters 0.
REQ-033 A write pending for the cycle after an acceptance SHALL be cancelled by reset; no mem_we pulse SHALL occur while reset is high or in the first cycle after its release.

Verification
REQ-034 start; stream 8'h00, 8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h60 -> 8'h00 discarded; writes (0,10),(1,20),(2,30); done=1, cpu_hold=0, error=0.
REQ-035 Same stream with last byte 8'h61 -> three writes occur, then error=1, done=0, cpu_hold=1.
REQ-036 start; A5, 00, bytes 8'h00..8'hFF, checksum 8'h80 -> 256 writes, addresses 0..255, done=1.
REQ-037 start; A5, 02, one payload byte, then rx_valid low for TIMEOUT cycles -> ERR, error=1, exactly one write.
REQ-038 reset pulsed in the cycle after the 2nd payload byte is accepted -> no write to address 1; IDLE, all outputs at reset values; a subsequent full session completes with done=1.
REQ-039 start asserted while in LOAD -> ignored; byte count and addresses continue unchanged.
